// File: rtl/cachebusarb_pkg.sv
// Shared types for the cache-line bus arbiter: FSM state and bus request encodings.
// Latency: none (types, constants and one pure helper).
// Backpressure: not applicable.
package cachebusarb_pkg;

  typedef enum logic [1:0] {IDLE, BUSYI, BUSYD} cachebusarbstatetype;

  // BusRW encodings: [1] read/fetch, [0] write/writeback
  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;

  // The D$ should never ask for 11; if it does, the writeback half wins.
  function automatic logic [1:0] normDCacheRW(input logic [1:0] rw);
    return rw[0] ? RW_WRITE : rw;
  endfunction

endpackage

// File: rtl/cachebusarb_beatctr.sv
// Beat counter for one cache line: counts accepted beats and flags the final one.
// Latency: count updates the cycle after each enabled beat; last is combinational.
// Backpressure: holds its value on cycles without an accepted beat.
module cachebusbeatctr #(
  parameter int LOGBWPL = 3
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               en,
  output logic [LOGBWPL-1:0] count,
  output logic               last
);

  // Count accepted beats; natural wrap from BEATSPERLINE-1 back to 0.
  always_ff @(posedge clk) begin
    if (clear)   count <= '0;
    else if (en) count <= count + 1'b1;
  end

  assign last = en & (count == {LOGBWPL{1'b1}});

endmodule

// File: rtl/cachebusarb.sv
// Arbitrates the shared cache-line bus between I$ and D$; define CACHEBUSARB_RR_EN for round-robin ties.
// Latency: request sampled in IDLE, BusRW valid next cycle; ack combinational with the final BeatDone.
// Backpressure: beats advance only on BeatDone; losing requester simply waits with its request held.
module cachebusarb import cachebusarb_pkg::*; #(
  parameter int PA_BITS = 34,
  parameter int LOGBWPL = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         ICacheBusRW,
  input  logic [PA_BITS-1:0] ICacheBusAdr,
  output logic               ICacheBusAck,
  input  logic [1:0]         DCacheBusRW,
  input  logic [PA_BITS-1:0] DCacheBusAdr,
  output logic               DCacheBusAck,
  output logic [1:0]         BusRW,
  output logic [PA_BITS-1:0] BusAdr,
  input  logic               BeatDone,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               IGnt,
  output logic               DGnt,
  output logic               BusCommitted
);

  cachebusarbstatetype state;
  logic [1:0]          ownRW;
  logic [PA_BITS-1:0]  ownAdr;
  logic                iReq, dReq, pickD, busy, lastBeat, lockFetch;
  logic                unusedIRw0;

  // I$ never writes back, so its low RW bit carries no information.
  assign unusedIRw0 = ICacheBusRW[0];

  assign iReq = ICacheBusRW[1];
  assign dReq = |DCacheBusRW;
  assign busy = (state != IDLE);

`ifdef CACHEBUSARB_RR_EN
  logic rrPtrI;  // 1: I$ wins the next tie, 0: D$ wins

  assign pickD = dReq & (~iReq | ~rrPtrI);

  // Point the tie-break at the other cache once a grant finishes; the locked fetch is not a new grant.
  always_ff @(posedge clk) begin
    if (reset)                          rrPtrI <= 1'b0;
    else if (lastBeat & ~lockFetch)     rrPtrI <= (state == BUSYD);
  end
`else
  assign pickD = dReq;
`endif

  cachebusbeatctr #(.LOGBWPL(LOGBWPL)) beatCtr (
    .clk   (clk),
    .clear (reset | ~busy),
    .en    (BeatDone & busy),
    .count (BeatCount),
    .last  (lastBeat)
  );

  // A writeback that ends while the D$ already asks for its fetch keeps the bus without an IDLE bubble.
  assign lockFetch = (state == BUSYD) & lastBeat & (ownRW == RW_WRITE) & DCacheBusRW[1];

  // Arbiter FSM with owner request/address latches; live requests are ignored once committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ownRW  <= RW_NONE;
      ownAdr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pickD) begin
            state  <= BUSYD;
            ownRW  <= normDCacheRW(DCacheBusRW);
            ownAdr <= DCacheBusAdr;
          end else if (iReq) begin
            state  <= BUSYI;
            ownRW  <= RW_READ;
            ownAdr <= ICacheBusAdr;
          end
        end
        BUSYI, BUSYD: begin
          if (lockFetch) begin
            ownRW  <= RW_READ;
            ownAdr <= DCacheBusAdr;
          end else if (lastBeat) begin
            state <= IDLE;
            ownRW <= RW_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BusRW        = busy ? ownRW : RW_NONE;
  assign BusAdr       = ownAdr;
  assign IGnt         = (state == BUSYI);
  assign DGnt         = (state == BUSYD);
  assign BusCommitted = busy;
  assign ICacheBusAck = IGnt & lastBeat & ~reset;
  assign DCacheBusAck = DGnt & lastBeat & ~reset;

endmodule

// File: tb/tb_cachebusarb.sv
module tb_cachebusarb;
  localparam int PA = 34;
  localparam int LB = 3;
  localparam int NB = 8;
`ifdef CACHEBUSARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    ICacheBusRW = 2'b00;
  logic [PA-1:0] ICacheBusAdr = '0;
  logic          ICacheBusAck;
  logic [1:0]    DCacheBusRW = 2'b00;
  logic [PA-1:0] DCacheBusAdr = '0;
  logic          DCacheBusAck;
  logic [1:0]    BusRW;
  logic [PA-1:0] BusAdr;
  logic          BeatDone = 1'b0;
  logic [LB-1:0] BeatCount;
  logic          IGnt, DGnt, BusCommitted;

  always #5 clk = ~clk;

  cachebusarb #(.PA_BITS(PA), .LOGBWPL(LB)) dut (
    .clk(clk), .reset(reset),
    .ICacheBusRW(ICacheBusRW), .ICacheBusAdr(ICacheBusAdr), .ICacheBusAck(ICacheBusAck),
    .DCacheBusRW(DCacheBusRW), .DCacheBusAdr(DCacheBusAdr), .DCacheBusAck(DCacheBusAck),
    .BusRW(BusRW), .BusAdr(BusAdr), .BeatDone(BeatDone), .BeatCount(BeatCount),
    .IGnt(IGnt), .DGnt(DGnt), .BusCommitted(BusCommitted)
  );

  int nChecks = 0;
  int nFail   = 0;

  // Reference model: who owns the line, what it asked for, how many beats are done.
  int            mOwner   = 0;      // 0 none, 1 I$, 2 D$
  logic [1:0]    mRW      = 2'b00;
  logic [PA-1:0] mAdr     = '0;
  int            mBeats   = 0;
  bit            mPreferI = 1'b0;
  bit            mLast, iR, dR, winD;

  // D$ agent: a writeback that wants its fetch presented in the ack cycle
  bit            dPair    = 1'b0;
  logic [PA-1:0] dPairAdr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT to the model each cycle, then advance the model on the same sampled inputs.
  always @(negedge clk) begin
    mLast = (mOwner != 0) && BeatDone && (mBeats == NB - 1);
    check("BusRW", BusRW, (mOwner != 0) ? mRW : 2'b00);
    if (mOwner != 0) check("BusAdr", BusAdr, mAdr);
    check("BeatCount", BeatCount, (mOwner != 0) ? 64'(mBeats) : 64'd0);
    check("IGnt", IGnt, mOwner == 1);
    check("DGnt", DGnt, mOwner == 2);
    check("BusCommitted", BusCommitted, mOwner != 0);
    check("ICacheBusAck", ICacheBusAck, mLast && mOwner == 1 && !reset);
    check("DCacheBusAck", DCacheBusAck, mLast && mOwner == 2 && !reset);

    if (reset) begin
      mOwner = 0; mBeats = 0; mPreferI = 1'b0; mRW = 2'b00;
    end else if (mOwner == 0) begin
      iR   = ICacheBusRW[1];
      dR   = (DCacheBusRW != 2'b00);
      winD = dR && (!iR || !RR || !mPreferI);
      if (winD) begin
        mOwner = 2; mRW = DCacheBusRW[0] ? 2'b01 : 2'b10; mAdr = DCacheBusAdr; mBeats = 0;
      end else if (iR) begin
        mOwner = 1; mRW = 2'b10; mAdr = ICacheBusAdr; mBeats = 0;
      end
    end else if (BeatDone) begin
      if (mBeats == NB - 1) begin
        if (mOwner == 2 && mRW == 2'b01 && DCacheBusRW[1]) begin
          mRW = 2'b10; mAdr = DCacheBusAdr; mBeats = 0;
        end else begin
          mPreferI = (mOwner == 2);
          mOwner = 0; mBeats = 0; mRW = 2'b00;
        end
      end else begin
        mBeats++;
      end
    end
  end

  function automatic logic [PA-1:0] randAdr();
    logic [PA-1:0] a;
    a = {2'($urandom_range(3, 0)), $urandom()};
    a[5:0] = 6'd0;
    return a;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Caches drop (or switch to the locked fetch) in the cycle their final beat is accepted.
  task automatic applyAck();
    if (BeatDone && !reset && mOwner != 0 && mBeats == NB - 1) begin
      if (mOwner == 1) ICacheBusRW = 2'b00;
      else if (dPair && mRW == 2'b01) begin
        DCacheBusRW = 2'b10; DCacheBusAdr = dPairAdr; dPair = 1'b0;
      end else DCacheBusRW = 2'b00;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mOwner != 0 || ICacheBusRW != 2'b00 || DCacheBusRW != 2'b00) && n < budget) begin
      BeatDone = 1'b1;
      applyAck();
      nextCycle();
      n++;
    end
    BeatDone = 1'b0;
    if (n >= budget) begin
      nChecks++; nFail++;
      $display("FAIL drain: bus still busy after %0d cycles", budget);
    end
  endtask

  initial begin
    int cnt;
    int r;
    // Reset state
    nextCycle();
    @(negedge clk);
    check("rst BusRW", BusRW, 2'b00);
    check("rst BeatCount", BeatCount, 0);
    check("rst Gnt", {IGnt, DGnt, BusCommitted}, 3'b000);
    nextCycle();
    reset = 1'b0;

    // I$ only, one line
    ICacheBusRW = 2'b10; ICacheBusAdr = 34'h0_8000_1040;
    @(negedge clk);
    check("t1 idle", BusCommitted, 1'b0);
    nextCycle();
    @(negedge clk);
    check("t1 BusRW", BusRW, 2'b10);
    check("t1 BusAdr", BusAdr, 34'h0_8000_1040);
    for (int k = 0; k < NB; k++) begin
      nextCycle(); BeatDone = 1'b1; applyAck();
      @(negedge clk);
      check("t1 ack", ICacheBusAck, k == NB - 1);
      check("t1 beat", BeatCount, k);
    end
    nextCycle(); BeatDone = 1'b0;
    @(negedge clk);
    check("t1 back idle", {IGnt, BusCommitted, BusRW}, 4'b0000);
    nextCycle();

    // Simultaneous requests
    ICacheBusRW = 2'b10; ICacheBusAdr = 34'h0_8000_2100;
    DCacheBusRW = 2'b10; DCacheBusAdr = 34'h0_8000_3200;
    nextCycle();
    @(negedge clk);
    check("t2 first D", {IGnt, DGnt}, 2'b01);
    for (int k = 0; k < NB; k++) begin
      nextCycle(); BeatDone = 1'b1; applyAck();
    end
    nextCycle(); BeatDone = 1'b0;
    DCacheBusRW = 2'b10; DCacheBusAdr = 34'h0_8000_3240;
    nextCycle();
    @(negedge clk);
    check("t2 second tie", {IGnt, DGnt}, RR ? 2'b10 : 2'b01);
    nextCycle();
    drain(200);

    // Writeback-then-fetch lock with I$ pending
    DCacheBusRW = 2'b01; DCacheBusAdr = 34'h0_8000_2000;
    dPair = 1'b1; dPairAdr = 34'h0_8000_3000;
    nextCycle();
    ICacheBusRW = 2'b10; ICacheBusAdr = 34'h0_8000_4000;
    @(negedge clk);
    check("t3 wb grant", {DGnt, BusRW}, 3'b101);
    check("t3 wb adr", BusAdr, 34'h0_8000_2000);
    for (int k = 0; k < NB; k++) begin
      nextCycle(); BeatDone = 1'b1; applyAck();
      @(negedge clk);
      check("t3 wb ack", DCacheBusAck, k == NB - 1);
      check("t3 wb DGnt", DGnt, 1'b1);
    end
    nextCycle(); BeatDone = 1'b0;
    @(negedge clk);
    check("t3 lock", {DGnt, IGnt, BusRW}, 4'b1010);
    check("t3 lock adr", BusAdr, 34'h0_8000_3000);
    check("t3 lock beat", BeatCount, 0);
    for (int k = 0; k < NB; k++) begin
      nextCycle(); BeatDone = 1'b1; applyAck();
      @(negedge clk);
      check("t3 fetch ack", DCacheBusAck, k == NB - 1);
      check("t3 fetch gnt", {DGnt, IGnt}, 2'b10);
    end
    nextCycle(); BeatDone = 1'b0;
    @(negedge clk);
    check("t3 idle gap", BusCommitted, 1'b0);
    nextCycle();
    @(negedge clk);
    check("t3 I after", IGnt, 1'b1);
    check("t3 I adr", BusAdr, 34'h0_8000_4000);
    nextCycle();
    drain(200);

    // Gaps in BeatDone
    DCacheBusRW = 2'b10; DCacheBusAdr = 34'h0_8000_5000;
    nextCycle();
    cnt = 0;
    for (int c = 0; c < 11; c++) begin
      nextCycle(); BeatDone = !(c >= 3 && c <= 5); applyAck();
      @(negedge clk);
      if (!BeatDone) check("t4 hold", BeatCount, 3);
      check("t4 ack", DCacheBusAck, BeatDone && cnt == NB - 1);
      if (BeatDone) cnt++;
    end
    nextCycle(); BeatDone = 1'b0;
    drain(200);

    // Reset mid-transfer
    DCacheBusRW = 2'b10; DCacheBusAdr = 34'h0_8000_6000;
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      nextCycle(); BeatDone = 1'b1;
    end
    nextCycle(); BeatDone = 1'b0;
    @(negedge clk);
    check("t5 beat4", BeatCount, 4);
    nextCycle(); reset = 1'b1; BeatDone = 1'b1;
    nextCycle(); reset = 1'b0; BeatDone = 1'b0;
    @(negedge clk);
    check("t5 post rst", {BusCommitted, DGnt, BusRW, DCacheBusAck}, 5'b00000);
    check("t5 post rst beat", BeatCount, 0);
    nextCycle();
    @(negedge clk);
    check("t5 regrant", {DGnt, BusRW}, 3'b110);
    check("t5 regrant beat", BeatCount, 0);
    nextCycle();
    drain(200);

    // I$ request withdrawn while D$ owns the bus
    DCacheBusRW = 2'b10; DCacheBusAdr = 34'h0_8000_7000;
    nextCycle();
    ICacheBusRW = 2'b10; ICacheBusAdr = 34'h0_8000_7100;
    BeatDone = 1'b1; applyAck();
    @(negedge clk);
    check("t6 IGnt", IGnt, 1'b0);
    for (int k = 0; k < NB + 2; k++) begin
      nextCycle(); ICacheBusRW = 2'b00; BeatDone = 1'b1; applyAck();
      @(negedge clk);
      check("t6 IGnt", IGnt, 1'b0);
    end
    nextCycle();
    drain(200);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(999, 0) == 0);
      BeatDone = ($urandom_range(2, 0) != 0);
      if (ICacheBusRW == 2'b00) begin
        if ($urandom_range(5, 0) == 0) begin
          ICacheBusRW = 2'b10; ICacheBusAdr = randAdr();
        end
      end else if (mOwner != 1 && $urandom_range(29, 0) == 0) ICacheBusRW = 2'b00;
      if (DCacheBusRW == 2'b00) begin
        if ($urandom_range(4, 0) == 0) begin
          r = $urandom_range(9, 0);
          DCacheBusAdr = randAdr();
          dPair = 1'b0;
          if (r < 4)      DCacheBusRW = 2'b10;
          else if (r < 7) DCacheBusRW = 2'b01;
          else if (r < 9) begin DCacheBusRW = 2'b01; dPair = 1'b1; dPairAdr = randAdr(); end
          else            DCacheBusRW = 2'b11;
        end
      end else if (mOwner != 2 && $urandom_range(29, 0) == 0) begin
        DCacheBusRW = 2'b00; dPair = 1'b0;
      end
      applyAck();
      nextCycle();
    end
    reset = 1'b0;
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
